// File: rtl/stall_ctrl.sv
// stall_ctrl: central stall controller for the five-stage MIPS pipeline.
// Detects forwarding-unsatisfiable data hazards and sequences the MDU busy window.
module stall_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  D_rs,
    input  logic [4:0]  D_rt,
    input  logic [1:0]  D_Tuse_rs,
    input  logic [1:0]  D_Tuse_rt,
    input  logic        D_MD,
    input  logic [4:0]  E_A3,
    input  logic [1:0]  E_Tnew,
    input  logic [4:0]  M_A3,
    input  logic [1:0]  M_Tnew,
    input  logic        E_Start,
    input  logic        E_IsDiv,
    output logic        stall,
    output logic        PC_en,
    output logic        FD_en,
    output logic        DE_clr,
    output logic        md_busy,
    output logic        md_done,
    output logic [3:0]  md_cnt,
    output logic [31:0] stall_total
);

    localparam logic [3:0] MultLoad = 4'(MULT_CYCLES);
    localparam logic [3:0] DivLoad  = 4'(DIV_CYCLES);
    localparam logic [1:0] TuseNone = 2'd3;

    logic [3:0]  md_cnt_q, md_cnt_d;
    logic        md_done_q, md_done_d;
    logic [31:0] stall_total_q, stall_total_d;
    logic        rs_hz, rt_hz, md_hz;

    // A producer blocks an operand only if it writes that register and its
    // result becomes forwardable later than the consumer needs it.
    function automatic logic prod_hz(input logic [4:0] src, input logic [1:0] tuse,
                                     input logic [4:0] a3, input logic [1:0] tnew);
        return (a3 != 5'd0) && (src == a3) && (tuse < tnew);
    endfunction

    always_comb begin
        rs_hz = (D_Tuse_rs != TuseNone) &&
                (prod_hz(D_rs, D_Tuse_rs, E_A3, E_Tnew) ||
                 prod_hz(D_rs, D_Tuse_rs, M_A3, M_Tnew));
        rt_hz = (D_Tuse_rt != TuseNone) &&
                (prod_hz(D_rt, D_Tuse_rt, E_A3, E_Tnew) ||
                 prod_hz(D_rt, D_Tuse_rt, M_A3, M_Tnew));
    end

    assign md_busy = (md_cnt_q != 4'd0);
    assign md_hz   = D_MD && (E_Start || md_busy);
    assign stall   = rs_hz || rt_hz || md_hz;
    assign PC_en   = ~stall;
    assign FD_en   = ~stall;
    assign DE_clr  = stall;

    always_comb begin
        md_cnt_d = md_cnt_q;
        // A start while the unit is still occupied is ignored, never reloaded.
        if (E_Start && (md_cnt_q == 4'd0)) begin
            md_cnt_d = E_IsDiv ? DivLoad : MultLoad;
        end else if (md_cnt_q != 4'd0) begin
            md_cnt_d = md_cnt_q - 4'd1;
        end

        md_done_d = (md_cnt_q == 4'd1);

        stall_total_d = stall_total_q;
        if (stall && (stall_total_q != 32'hFFFF_FFFF)) begin
            stall_total_d = stall_total_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            md_cnt_q      <= 4'd0;
            md_done_q     <= 1'b0;
            stall_total_q <= 32'd0;
        end else begin
            md_cnt_q      <= md_cnt_d;
            md_done_q     <= md_done_d;
            stall_total_q <= stall_total_d;
        end
    end

    assign md_cnt      = md_cnt_q;
    assign md_done     = md_done_q;
    assign stall_total = stall_total_q;

endmodule

// File: tb/tb_stall_ctrl.sv
// Self-checking bench for stall_ctrl: directed test-plan cases plus randomized
// stimulus compared every cycle against a behavioural timeline model.
module tb_stall_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  D_rs, D_rt, E_A3, M_A3;
    logic [1:0]  D_Tuse_rs, D_Tuse_rt, E_Tnew, M_Tnew;
    logic        D_MD, E_Start, E_IsDiv;
    logic        stall, PC_en, FD_en, DE_clr, md_busy, md_done;
    logic [3:0]  md_cnt;
    logic [31:0] stall_total;

    int n_checks = 0;
    int n_err    = 0;
    bit chk_en   = 1'b0;

    // Model: the MDU is a time window (busy through busy_until, done at done_at).
    int          cyc        = 0;
    int          busy_until = -1;
    int          done_at    = -1;
    logic [31:0] m_total    = 32'd0;
    logic        e_stall, e_done;
    logic [3:0]  e_cnt;

    stall_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset),
        .D_rs(D_rs), .D_rt(D_rt), .D_Tuse_rs(D_Tuse_rs), .D_Tuse_rt(D_Tuse_rt),
        .D_MD(D_MD), .E_A3(E_A3), .E_Tnew(E_Tnew), .M_A3(M_A3), .M_Tnew(M_Tnew),
        .E_Start(E_Start), .E_IsDiv(E_IsDiv),
        .stall(stall), .PC_en(PC_en), .FD_en(FD_en), .DE_clr(DE_clr),
        .md_busy(md_busy), .md_done(md_done), .md_cnt(md_cnt), .stall_total(stall_total)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic operand_blocked(input logic [4:0] src, input logic [1:0] tuse);
        logic [4:0] dst [2];
        int         ready [2];
        dst[0] = E_A3;  ready[0] = int'(E_Tnew);
        dst[1] = M_A3;  ready[1] = int'(M_Tnew);
        if (tuse == 2'd3) return 1'b0;
        for (int p = 0; p < 2; p++) begin
            if (dst[p] != 5'd0 && dst[p] == src && int'(tuse) < ready[p]) return 1'b1;
        end
        return 1'b0;
    endfunction

    always @(negedge clk) begin
        e_cnt   = (busy_until >= cyc) ? 4'(busy_until - cyc + 1) : 4'd0;
        e_done  = (done_at == cyc);
        e_stall = operand_blocked(D_rs, D_Tuse_rs) || operand_blocked(D_rt, D_Tuse_rt) ||
                  (D_MD && (E_Start || e_cnt != 4'd0));
        if (chk_en) begin
            check("stall", 32'(stall), 32'(e_stall));
            check("PC_en", 32'(PC_en), 32'(!e_stall));
            check("FD_en", 32'(FD_en), 32'(!e_stall));
            check("DE_clr", 32'(DE_clr), 32'(e_stall));
            check("md_cnt", 32'(md_cnt), 32'(e_cnt));
            check("md_busy", 32'(md_busy), 32'(e_cnt != 4'd0));
            check("md_done", 32'(md_done), 32'(e_done));
            check("stall_total", stall_total, m_total);
        end
        if (reset) begin
            busy_until = -1;
            done_at    = -1;
            m_total    = 32'd0;
        end else begin
            if (E_Start && e_cnt == 4'd0) begin
                busy_until = cyc + (E_IsDiv ? 10 : 5);
                done_at    = busy_until + 1;
            end
            if (e_stall && m_total != 32'hFFFF_FFFF) m_total = m_total + 32'd1;
        end
        cyc++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reset = 1'b0; D_rs = 5'd0; D_rt = 5'd0; D_Tuse_rs = 2'd3; D_Tuse_rt = 2'd3;
        D_MD = 1'b0; E_A3 = 5'd0; E_Tnew = 2'd0; M_A3 = 5'd0; M_Tnew = 2'd0;
        E_Start = 1'b0; E_IsDiv = 1'b0;
    endtask

    task automatic load_use();
        idle();
        D_rs = 5'd8; D_Tuse_rs = 2'd0; E_A3 = 5'd8; E_Tnew = 2'd2;
    endtask

    int busy_n, done_n, done_k;

    initial begin
        idle();
        reset = 1'b1;
        step(); step();
        chk_en = 1'b1;

        // Reset state
        idle(); @(negedge clk);
        check("rst md_cnt", 32'(md_cnt), 32'd0);
        check("rst md_done", 32'(md_done), 32'd0);
        check("rst stall_total", stall_total, 32'd0);
        check("idle stall", 32'(stall), 32'd0);

        // Load-use from E, then from M, then resolved
        step(); load_use(); @(negedge clk);
        check("lu stall", 32'(stall), 32'd1);
        check("lu PC_en", 32'(PC_en), 32'd0);
        check("lu DE_clr", 32'(DE_clr), 32'd1);
        step(); E_A3 = 5'd0; M_A3 = 5'd8; M_Tnew = 2'd1; @(negedge clk);
        check("lu M stall", 32'(stall), 32'd1);
        step(); M_Tnew = 2'd0; @(negedge clk);
        check("lu M ready", 32'(stall), 32'd0);

        // $0 never stalls; unused operand never stalls
        step(); idle(); D_Tuse_rs = 2'd0; E_Tnew = 2'd2; @(negedge clk);
        check("r0 stall", 32'(stall), 32'd0);
        step(); idle(); D_Tuse_rt = 2'd3; D_rt = 5'd5; E_A3 = 5'd5; E_Tnew = 2'd2;
        @(negedge clk);
        check("unused rt", 32'(stall), 32'd0);

        // Multiply sequencing
        step(); idle(); reset = 1'b1; @(negedge clk);
        step(); idle(); E_Start = 1'b1; D_MD = 1'b1; @(negedge clk);
        check("mul c0 stall", 32'(stall), 32'd1);
        for (int k = 1; k <= 5; k++) begin
            step(); E_Start = 1'b0; @(negedge clk);
            check("mul stall", 32'(stall), 32'd1);
            check("mul cnt", 32'(md_cnt), 32'(6 - k));
            check("mul no done", 32'(md_done), 32'd0);
        end
        step(); @(negedge clk);
        check("mul c6 done", 32'(md_done), 32'd1);
        check("mul c6 stall", 32'(stall), 32'd0);
        step(); D_MD = 1'b0; @(negedge clk);
        check("mul c7 done", 32'(md_done), 32'd0);

        // Divide sequencing
        step(); idle(); E_Start = 1'b1; E_IsDiv = 1'b1; @(negedge clk);
        busy_n = 0; done_n = 0; done_k = -1;
        for (int k = 1; k <= 14; k++) begin
            step(); E_Start = 1'b0; @(negedge clk);
            busy_n += int'(md_busy);
            if (md_done) begin done_n++; done_k = k; end
        end
        check("div busy cycles", 32'(busy_n), 32'd10);
        check("div done count", 32'(done_n), 32'd1);
        check("div done cycle", 32'(done_k), 32'd11);

        // Reset mid-divide at md_cnt == 4
        step(); idle(); E_Start = 1'b1; E_IsDiv = 1'b1; @(negedge clk);
        for (int k = 1; k <= 7; k++) begin
            step(); E_Start = 1'b0; @(negedge clk);
        end
        check("div cnt before rst", 32'(md_cnt), 32'd4);
        step(); reset = 1'b1; @(negedge clk);
        step(); reset = 1'b0; @(negedge clk);
        check("rst md_cnt mid", 32'(md_cnt), 32'd0);
        check("rst md_busy mid", 32'(md_busy), 32'd0);
        check("rst stall_total mid", stall_total, 32'd0);
        done_n = 0;
        for (int k = 0; k < 15; k++) begin
            step(); @(negedge clk);
            done_n += int'(md_done);
        end
        check("no done after rst", 32'(done_n), 32'd0);

        // Stall counter: 7 stalled cycles after reset
        step(); idle(); reset = 1'b1; @(negedge clk);
        for (int k = 0; k < 7; k++) begin
            step(); load_use(); @(negedge clk);
        end
        step(); idle(); @(negedge clk);
        check("total 7", stall_total, 32'd7);

        // Saturation from a preloaded near-max value
        step(); idle();
        dut.stall_total_q = 32'hFFFF_FFFE;
        m_total = 32'hFFFF_FFFE;
        @(negedge clk);
        check("total preload", stall_total, 32'hFFFF_FFFE);
        for (int k = 0; k < 3; k++) begin
            step(); load_use(); @(negedge clk);
        end
        step(); idle(); @(negedge clk);
        check("total saturated", stall_total, 32'hFFFF_FFFF);

        // Randomized traffic against the model
        step(); idle(); reset = 1'b1; @(negedge clk);
        for (int k = 0; k < 3000; k++) begin
            step();
            reset     = ($urandom_range(0, 99) < 2);
            D_rs      = 5'($urandom_range(0, 3));
            D_rt      = 5'($urandom_range(0, 3));
            D_Tuse_rs = 2'($urandom_range(0, 3));
            D_Tuse_rt = 2'($urandom_range(0, 3));
            D_MD      = ($urandom_range(0, 99) < 30);
            E_A3      = 5'($urandom_range(0, 3));
            E_Tnew    = 2'($urandom_range(0, 2));
            M_A3      = 5'($urandom_range(0, 3));
            M_Tnew    = 2'($urandom_range(0, 1));
            E_Start   = ($urandom_range(0, 99) < 20);
            E_IsDiv   = 1'($urandom_range(0, 1));
            @(negedge clk);
        end

        step(); idle(); @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/stall_ctrl.md
# stall_ctrl

Central pipeline stall controller for the five-stage MIPS core. It stalls an instruction in D when an operand producer in E or M cannot yet supply a forwarded value. It also owns the multiply/divide unit (MDU) occupancy counter: it sequences the MDU busy window, stalls MDU instructions in D while the unit is occupied, and signals when HI/LO results are ready. Its outputs drive the PC enable, the F/D register enable and the D/E register clear.

## Interface
Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu after start (1..15)
- DIV_CYCLES, 10, busy cycles for div/divu after start (1..15)

Ports:
- clk  in  1  system clock, all state updates on its rising edge
- reset  in  1  synchronous, active-high; clears all state at the next rising edge
- D_rs  in  5  rs field of the instruction in D
- D_rt  in  5  rt field of the instruction in D
- D_Tuse_rs  in  2  cycles until D needs rs (0,1; 3 = not used)
- D_Tuse_rt  in  2  cycles until D needs rt (0,1,2; 3 = not used)
- D_MD  in  1  D holds mult/multu/div/divu/mfhi/mflo/mthi/mtlo
- E_A3  in  5  destination register of the instruction in E (0 = none)
- E_Tnew  in  2  cycles until E's result is forwardable (0..2)
- M_A3  in  5  destination register of the instruction in M
- M_Tnew  in  2  cycles until M's result is forwardable (0..1)
- E_Start  in  1  E holds mult/multu/div/divu (one-cycle qualifier)
- E_IsDiv  in  1  with E_Start: 1 = div/divu, 0 = mult/multu
- stall  out  1  combinational; D instruction must wait
- PC_en  out  1  = ~stall
- FD_en  out  1  = ~stall
- DE_clr  out  1  = stall (insert bubble into E)
- md_busy  out  1  MDU occupied (md_cnt != 0)
- md_done  out  1  registered one-cycle pulse: HI/LO result valid
- md_cnt  out  4  remaining busy cycles
- stall_total  out  32  saturating count of stalled cycles

## Operation
- Data-hazard stall (combinational):
  - rs_hz = D_Tuse_rs != 3 && ((D_rs == E_A3 && E_A3 != 0 && D_Tuse_rs < E_Tnew) || (D_rs == M_A3 && M_A3 != 0 && D_Tuse_rs < M_Tnew)).
  - rt_hz is the same expression using D_rt and D_Tuse_rt.
  - The W stage never causes a stall.
- MDU stall: md_hz = D_MD && (E_Start || md_busy).
- Combined stall: stall = rs_hz || rt_hz || md_hz.
- MDU counter (md_cnt, 4-bit register):
  - If reset: md_cnt <= 0.
  - Else if E_Start && md_cnt == 0: md_cnt <= E_IsDiv ? DIV_CYCLES : MULT_CYCLES.
  - Else if md_cnt != 0: md_cnt <= md_cnt - 1.
  - E_Start while md_cnt != 0 is a protocol violation (md_hz prevents it). It is ignored: the counter keeps decrementing and is not reloaded.
- md_done: md_done <= ~reset && (md_cnt == 1). This gives exactly one pulse per operation, in the first cycle md_cnt == 0.
- stall_total:
  - If reset: 0.
  - Else if stall and the value is not 32'hFFFFFFFF: increment.
  - It holds at 32'hFFFFFFFF.
- No arithmetic beyond 4-bit decrement and 32-bit increment; comparisons are unsigned.

## Timing
- Reset values:
  - md_cnt = 0, md_busy = 0, md_done = 0, stall_total = 0.
  - stall, PC_en, FD_en and DE_clr follow their inputs combinationally.
- The stall path is zero-latency: asserted in the same cycle as the hazard condition.
- A stalled D instruction is held. E receives a bubble (E_A3 = 0, E_Tnew = 0, E_Start = 0) at the next edge.
- MDU start in E during cycle t:
  - md_cnt = N during cycle t+1 and md_busy = 1 for cycles t+1..t+N.
  - md_done = 1 in cycle t+N+1 only.
- An MDU instruction in D during cycle t (start in E) stalls. It keeps stalling through cycle t+N and proceeds in cycle t+N+1.
- Reset mid-operation: at the next edge md_cnt = 0, and md_done stays 0 that cycle and afterwards. Any pending done is discarded.
- Reset has priority over E_Start in the same cycle.

## Test plan
- Load-use hazard:
  - Stimulus: D_rs = 8, D_Tuse_rs = 0, E_A3 = 8, E_Tnew = 2.
  - Required: stall = 1, PC_en = 0, DE_clr = 1.
  - Then set E_A3 = 0 and M_A3 = 8, M_Tnew = 1. Required: stall = 1.
  - Then set M_Tnew = 0. Required: stall = 0.
- Register $0 and unused operand:
  - Stimulus 1: E_A3 = 0, D_rs = 0, E_Tnew = 2, D_Tuse_rs = 0. Required: stall = 0.
  - Stimulus 2: D_Tuse_rt = 3, D_rt = E_A3 = 5. Required: stall = 0.
- Multiply sequencing:
  - Stimulus: E_Start = 1, E_IsDiv = 0 at cycle 0, with D_MD = 1 held.
  - Required: stall = 1 for cycles 0..5. md_cnt reads 5,4,3,2,1 in cycles 1..5. md_done = 1 only in cycle 6, when stall = 0.
- Divide sequencing:
  - Stimulus: E_IsDiv = 1.
  - Required: md_busy = 1 for exactly 10 cycles, and md_done pulses once, 11 cycles after start.
- Reset mid-divide:
  - Stimulus: assert reset when md_cnt = 4.
  - Required: md_cnt = 0, md_busy = 0, stall_total = 0 the next cycle, and no md_done pulse ever follows.
- Stall counter:
  - Stimulus 1: 7 stalled cycles after reset. Required: stall_total = 7.
  - Stimulus 2: force stall_total = 32'hFFFFFFFF (via a preload in the bench), then stall again. Required: stall_total remains 32'hFFFFFFFF.
